// File: rtl/alu4_ctrl_if.sv
// Command, result and ALU-bus signals of the 4-bit ALU sequencer.
// master: the sequencer; slave: the host/ALU side.
interface alu4_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [1:0] cmd_cnt;
    logic [2:0] S;
    logic [3:0] A;
    logic [3:0] B;
    logic [4:0] Alu;
    logic       res_valid;
    logic       res_ready;
    logic [4:0] res_data;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, cmd_cnt,
        input  Alu, res_ready,
        output cmd_ready, S, A, B, res_valid, res_data
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, cmd_cnt,
        output Alu, res_ready,
        input  cmd_ready, S, A, B, res_valid, res_data
    );
endinterface

// File: rtl/alu4_ctrl.sv
// Sequencer driving a 4-bit ALU from an accumulator, 1-4 passes per command.
// Optional ALU4_CTRL_SAT_EN: saturate add/sub captures instead of wrapping.
module alu4_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    alu4_ctrl_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] acc_q, acc_d;
    logic       flag_q, flag_d;
    logic [2:0] op_q, op_d;
    logic [3:0] opnd_q, opnd_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] cap;
    logic       exec;

    assign exec = (state_q == EXEC);

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_data  = (state_q == DONE) ? {flag_q, acc_q} : 5'h00;
    assign bus.S         = exec ? op_q   : 3'd0;
    assign bus.A         = exec ? acc_q  : 4'd0;
    assign bus.B         = exec ? opnd_q : 4'd0;

    always_comb begin
        cap = bus.Alu[3:0];
`ifdef ALU4_CTRL_SAT_EN
        if (bus.Alu[4]) begin
            if (op_q == 3'd0)
                cap = 4'hF;
            else if (op_q == 3'd1)
                cap = 4'h0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        flag_d  = flag_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    opnd_d  = bus.cmd_data;
                    cnt_d   = bus.cmd_cnt;
                    flag_d  = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                acc_d  = cap;
                flag_d = flag_q | bus.Alu[4];
                cnt_d  = cnt_q - 2'd1;
                if (cnt_q == 2'd0)
                    state_d = DONE;
            end
            DONE: begin
                if (bus.res_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 4'd0;
            flag_q  <= 1'b0;
            op_q    <= 3'd0;
            opnd_q  <= 4'd0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            flag_q  <= flag_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
